// File: rtl/usb_rx_pkg.sv
// Shared definitions for the USB receive byte assembler: FSM state encoding,
// SYNC byte value and PID width.
// Optional feature macro used by the assembler: USB_RX_STUFF_ERR_EN.
package usb_rx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HUNT = 2'd1,
        RECV = 2'd2
    } rx_asm_state_t;

    // SYNC field (KJKJKJKK) as it appears after NRZI decode and LSB-first assembly
    localparam logic [7:0] SYNC_BYTE = 8'h80;

    // PID byte width (4-bit PID plus its complement)
    localparam int PID_W = 8;

    // A sample is a real data bit only when strobed, not stuffed and not SE0
    function automatic logic is_accepted(input logic shift_enable,
                                         input logic shift_stop,
                                         input logic eop);
        return shift_enable && !shift_stop && !eop;
    endfunction

endpackage

// File: rtl/usb_rx_byte_assembler_if.sv
// Bit-level input bundle and byte/status output bundle of the USB receive
// byte assembler. The stuff_error signal exists only when
// USB_RX_STUFF_ERR_EN is defined.
interface usb_rx_byte_assembler_if #(
    parameter int DATA_W = 8
);
    logic              d_orig;
    logic              d_edge;
    logic              shift_enable;
    logic              shift_stop;
    logic              eop;
    logic [DATA_W-1:0] rx_data;
    logic              rx_data_valid;
    logic              sync_detected;
    logic              rx_busy;
    logic              rx_done;
    logic              rx_error;
`ifdef USB_RX_STUFF_ERR_EN
    logic              stuff_error;
`endif

    // Upstream side: bit-unstuff stage feeding bits, consumers reading results
    modport master (
        output d_orig,
        output d_edge,
        output shift_enable,
        output shift_stop,
        output eop,
        input  rx_data,
        input  rx_data_valid,
        input  sync_detected,
        input  rx_busy,
        input  rx_done,
`ifdef USB_RX_STUFF_ERR_EN
        input  stuff_error,
`endif
        input  rx_error
    );

    // Assembler side
    modport slave (
        input  d_orig,
        input  d_edge,
        input  shift_enable,
        input  shift_stop,
        input  eop,
        output rx_data,
        output rx_data_valid,
        output sync_detected,
        output rx_busy,
        output rx_done,
`ifdef USB_RX_STUFF_ERR_EN
        output stuff_error,
`endif
        output rx_error
    );

endinterface

// File: rtl/rx_sipo_shift.sv
// Serial-in parallel-out right-shift register. New bits enter at the MSB so
// that after WIDTH shifts the first bit received sits in bit 0 (LSB-first).
module rx_sipo_shift #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clear,
    input  logic             shift,
    input  logic             din,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_reg;

    // Clear wins over shift so a fresh hunt always starts from all zeros
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            q_reg <= '0;
        end else if (clear) begin
            q_reg <= '0;
        end else if (shift) begin
            q_reg <= {din, q_reg[WIDTH-1:1]};
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/usb_rx_byte_assembler.sv
// USB receive byte assembler: hunts for SYNC, assembles LSB-first bytes and
// frames packets on EOP. All outputs are registered.
// Optional feature macro: USB_RX_STUFF_ERR_EN (adds stuff_error and treats a
// stuffed bit that is not zero as a packet error while receiving).
module usb_rx_byte_assembler
    import usb_rx_pkg::*;
#(
    parameter int              DATA_W       = 8,
    parameter logic [DATA_W-1:0] SYNC_PATTERN = SYNC_BYTE,
    parameter int              SYNC_TIMEOUT = 16
) (
    input  logic                    clk,
    input  logic                    n_rst,
    usb_rx_byte_assembler_if.slave  bus
);

    localparam int BIT_W  = $clog2(DATA_W);
    localparam int HUNT_W = $clog2(SYNC_TIMEOUT + 1);

    rx_asm_state_t     state;
    logic [BIT_W-1:0]  bit_cnt;
    logic [HUNT_W-1:0] hunt_cnt;
    logic [DATA_W-1:0] rx_data_q;
    logic              rx_data_valid_q;
    logic              sync_detected_q;
    logic              rx_busy_q;
    logic              rx_done_q;
    logic              rx_error_q;
`ifdef USB_RX_STUFF_ERR_EN
    logic              stuff_error_q;
`endif

    logic              accepted;
    logic              eop_strobe;
    logic              sr_clear;
    logic              sr_shift;
    logic [DATA_W-1:0] sr_q;
    logic [DATA_W-1:0] sr_shifted;

    assign accepted   = is_accepted(bus.shift_enable, bus.shift_stop, bus.eop);
    assign eop_strobe = bus.shift_enable && bus.eop;
    assign sr_clear   = (state == IDLE) && bus.d_edge;
    assign sr_shift   = accepted && (state != IDLE);
    // Value the shift register will hold after this accepted bit
    assign sr_shifted = {bus.d_orig, sr_q[DATA_W-1:1]};

    rx_sipo_shift #(
        .WIDTH (DATA_W)
    ) u_sipo (
        .clk   (clk),
        .n_rst (n_rst),
        .clear (sr_clear),
        .shift (sr_shift),
        .din   (bus.d_orig),
        .q     (sr_q)
    );

    // Framing FSM with counters and registered status/data outputs.
    // A SYNC match is only considered once a full byte has been shifted in
    // since the hunt started; otherwise the cleared register plus a single 1
    // would already look like 8'h80.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state           <= IDLE;
            bit_cnt         <= '0;
            hunt_cnt        <= '0;
            rx_data_q       <= '0;
            rx_data_valid_q <= 1'b0;
            sync_detected_q <= 1'b0;
            rx_busy_q       <= 1'b0;
            rx_done_q       <= 1'b0;
            rx_error_q      <= 1'b0;
`ifdef USB_RX_STUFF_ERR_EN
            stuff_error_q   <= 1'b0;
`endif
        end else begin
            rx_data_valid_q <= 1'b0;
            sync_detected_q <= 1'b0;
            rx_done_q       <= 1'b0;
            rx_error_q      <= 1'b0;
`ifdef USB_RX_STUFF_ERR_EN
            stuff_error_q   <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (bus.d_edge) begin
                        state     <= HUNT;
                        hunt_cnt  <= '0;
                        rx_busy_q <= 1'b1;
                    end
                end

                HUNT: begin
                    if (eop_strobe) begin
                        rx_error_q <= 1'b1;
                        state      <= IDLE;
                        rx_busy_q  <= 1'b0;
                    end else if (accepted) begin
                        hunt_cnt <= hunt_cnt + HUNT_W'(1);
                        if ((hunt_cnt >= HUNT_W'(DATA_W - 1)) &&
                            (sr_shifted == SYNC_PATTERN)) begin
                            sync_detected_q <= 1'b1;
                            state           <= RECV;
                            bit_cnt         <= '0;
                        end else if (hunt_cnt == HUNT_W'(SYNC_TIMEOUT - 1)) begin
                            rx_error_q <= 1'b1;
                            state      <= IDLE;
                            rx_busy_q  <= 1'b0;
                        end
                    end
                end

                RECV: begin
                    if (eop_strobe) begin
                        // Partial byte is dropped; rx_data keeps the last full byte
                        if (bit_cnt == '0) begin
                            rx_done_q <= 1'b1;
                        end else begin
                            rx_error_q <= 1'b1;
                        end
                        state     <= IDLE;
                        rx_busy_q <= 1'b0;
                    end else if (accepted) begin
                        bit_cnt <= bit_cnt + BIT_W'(1);
                        if (bit_cnt == BIT_W'(DATA_W - 1)) begin
                            rx_data_q       <= sr_shifted;
                            rx_data_valid_q <= 1'b1;
                        end
                    end
`ifdef USB_RX_STUFF_ERR_EN
                    else if (bus.shift_enable && bus.shift_stop && bus.d_orig) begin
                        // A stuffed bit must be a zero; a one means the bus is corrupt
                        stuff_error_q <= 1'b1;
                        rx_error_q    <= 1'b1;
                        state         <= IDLE;
                        rx_busy_q     <= 1'b0;
                    end
`endif
                end

                default: begin
                    state     <= IDLE;
                    rx_busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rx_data       = rx_data_q;
    assign bus.rx_data_valid = rx_data_valid_q;
    assign bus.sync_detected = sync_detected_q;
    assign bus.rx_busy       = rx_busy_q;
    assign bus.rx_done       = rx_done_q;
    assign bus.rx_error      = rx_error_q;
`ifdef USB_RX_STUFF_ERR_EN
    assign bus.stuff_error   = stuff_error_q;
`endif

endmodule
